harmonic_scheduler: RTL and testbench

- Per-output-sample sequencer for the additive harmonic datapath (sample-position / sine-LUT engine).
- On each sample-rate tick it walks harmonic indices 0..N-1, handshakes each harmonic's sample out of the datapath and sums the samples.
- Terminates early when the datapath flags a harmonic above the audible limit.
- Delivers one saturated 16-bit output sample per tick to the DAC/output stage.

---
 rtl/harmonic_scheduler.sv | 172 +++++++++++++++++
 tb/tb_harmonic_scheduler.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/harmonic_scheduler.sv
// Harmonic frame sequencer: per tick, sums N datapath samples into one saturated 16-bit output.
// Latency per harmonic: ready wait + SETTLE_CYCLES + 2 (+1 with HARMONIC_LEVEL_EN); ticks while busy are dropped and flagged on o_Overrun.
// Optional macro HARMONIC_LEVEL_EN adds odd/even harmonic level scaling.
module harmonic_scheduler #(
  parameter logic [7:0] MAX_HARMONICS = 8'd255,
  parameter int         SETTLE_CYCLES = 2,
  parameter int         ACC_WIDTH     = 24,
  parameter int         OUT_SHIFT     = 4
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_Sample_Tick,
  input  logic [7:0]  i_Harmonic_Count,
  input  logic        i_Sample_Ready,
  input  logic [15:0] i_Sample_Value,
  input  logic        i_Freq_Too_High,
`ifdef HARMONIC_LEVEL_EN
  input  logic [7:0]  i_Odd_Level,
  input  logic [7:0]  i_Even_Level,
`endif
  output logic [7:0]  o_Harmonic,
  output logic        o_Next_Sample,
  output logic [15:0] o_Sample,
  output logic        o_Sample_Valid,
  output logic        o_Busy,
  output logic        o_Overrun
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WAIT    = 3'd1;
  localparam logic [2:0] S_SETTLE  = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
`ifdef HARMONIC_LEVEL_EN
  localparam logic [2:0] S_MULT    = 3'd4;
`endif
  localparam logic [2:0] S_ADVANCE = 3'd5;
  localparam logic [2:0] S_FINISH  = 3'd6;

  localparam logic [2:0] SETTLE_LOAD = 3'(SETTLE_CYCLES - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(32767);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(-32768);

  logic [2:0]                  r_state;
  logic [2:0]                  r_settle;
  logic [7:0]                  r_count;
  logic [7:0]                  r_harmonic;
  logic signed [ACC_WIDTH-1:0] r_acc;
  logic                        r_next;
  logic [15:0]                 r_sample;
  logic                        r_valid;
  logic                        r_overrun;

  logic [7:0]                  w_count_min1;
  logic [8:0]                  w_count_diff;
  logic [7:0]                  w_count;
  logic                        w_last;
  logic signed [ACC_WIDTH-1:0] w_sext;
  logic signed [ACC_WIDTH-1:0] w_shift;
  logic [15:0]                 w_sat;

  assign w_count_min1 = (i_Harmonic_Count == 8'd0) ? 8'd1 : i_Harmonic_Count;
  assign w_count_diff = {1'b0, MAX_HARMONICS} - {1'b0, w_count_min1};
  assign w_count      = w_count_diff[8] ? MAX_HARMONICS : w_count_min1;
  assign w_last       = (r_harmonic == (r_count - 8'd1));
  assign w_sext       = {{(ACC_WIDTH-16){i_Sample_Value[15]}}, i_Sample_Value};
  assign w_shift      = r_acc >>> OUT_SHIFT;
  assign w_sat        = (w_shift > SAT_MAX) ? 16'h7FFF :
                        (w_shift < SAT_MIN) ? 16'h8000 : w_shift[15:0];

`ifdef HARMONIC_LEVEL_EN
  logic [7:0]                  w_level;
  logic signed [ACC_WIDTH-1:0] w_level_ext;
  logic signed [ACC_WIDTH-1:0] w_prod;
  logic signed [ACC_WIDTH-1:0] w_term;
  logic signed [ACC_WIDTH-1:0] r_term;

  // Index k carries harmonic number k+1, so even k selects the odd level.
  assign w_level     = r_harmonic[0] ? i_Even_Level : i_Odd_Level;
  assign w_level_ext = {{(ACC_WIDTH-8){1'b0}}, w_level};
  assign w_prod      = w_sext * w_level_ext;
  assign w_term      = (r_harmonic == 8'd0) ? w_sext : (w_prod >>> 8);
`endif

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_state    <= S_IDLE;
      r_settle   <= 3'd0;
      r_count    <= 8'd1;
      r_harmonic <= 8'd0;
      r_acc      <= '0;
      r_next     <= 1'b0;
      r_sample   <= 16'd0;
      r_valid    <= 1'b0;
      r_overrun  <= 1'b0;
`ifdef HARMONIC_LEVEL_EN
      r_term     <= '0;
`endif
    end else begin
      r_next    <= 1'b0;
      r_valid   <= 1'b0;
      r_overrun <= i_Sample_Tick && (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (i_Sample_Tick) begin
            r_count    <= w_count;
            r_acc      <= '0;
            r_harmonic <= 8'd0;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (i_Sample_Ready) begin
            r_settle <= SETTLE_LOAD;
            r_state  <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (r_settle == 3'd0) r_state <= S_CAPTURE;
          else                  r_settle <= r_settle - 3'd1;
        end
        S_CAPTURE: begin
          if (i_Freq_Too_High) begin
            r_harmonic <= 8'd0;
            r_next     <= 1'b1;
            r_sample   <= w_sat;
            r_valid    <= 1'b1;
            r_state    <= S_FINISH;
          end else begin
`ifdef HARMONIC_LEVEL_EN
            r_term  <= w_term;
            r_state <= S_MULT;
`else
            // Outputs change on entry so ADVANCE presents the new index with its pulse.
            r_acc      <= r_acc + w_sext;
            r_harmonic <= w_last ? 8'd0 : r_harmonic + 8'd1;
            r_next     <= !w_last;
            r_state    <= S_ADVANCE;
`endif
          end
        end
`ifdef HARMONIC_LEVEL_EN
        S_MULT: begin
          r_acc      <= r_acc + r_term;
          r_harmonic <= w_last ? 8'd0 : r_harmonic + 8'd1;
          r_next     <= !w_last;
          r_state    <= S_ADVANCE;
        end
`endif
        S_ADVANCE: begin
          if (r_next) begin
            r_state <= S_WAIT;
          end else begin
            r_next   <= 1'b1;
            r_sample <= w_sat;
            r_valid  <= 1'b1;
            r_state  <= S_FINISH;
          end
        end
        S_FINISH: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  assign o_Harmonic     = r_harmonic;
  assign o_Next_Sample  = r_next;
  assign o_Sample       = r_sample;
  assign o_Sample_Valid = r_valid;
  assign o_Busy         = (r_state != S_IDLE);
  assign o_Overrun      = r_overrun;

endmodule

// File: tb/tb_harmonic_scheduler.sv
// Scoreboard bench for harmonic_scheduler with a behavioural sample datapath model.
module tb_harmonic_scheduler;
  logic        clk = 1'b0;
  logic        i_Reset = 1'b1;
  logic        i_Sample_Tick = 1'b0;
  logic [7:0]  i_Harmonic_Count = 8'd0;
  logic        i_Sample_Ready = 1'b1;
  logic [15:0] i_Sample_Value = 16'd0;
  logic        i_Freq_Too_High = 1'b0;
  logic [7:0]  o_Harmonic;
  logic        o_Next_Sample;
  logic [15:0] o_Sample;
  logic        o_Sample_Valid;
  logic        o_Busy;
  logic        o_Overrun;
`ifdef HARMONIC_LEVEL_EN
  logic [7:0]  i_Odd_Level = 8'd255;
  logic [7:0]  i_Even_Level = 8'd255;
`endif

  always #5 clk = ~clk;

  harmonic_scheduler dut (
    .i_Clock          (clk),
    .i_Reset          (i_Reset),
    .i_Sample_Tick    (i_Sample_Tick),
    .i_Harmonic_Count (i_Harmonic_Count),
    .i_Sample_Ready   (i_Sample_Ready),
    .i_Sample_Value   (i_Sample_Value),
    .i_Freq_Too_High  (i_Freq_Too_High),
`ifdef HARMONIC_LEVEL_EN
    .i_Odd_Level      (i_Odd_Level),
    .i_Even_Level     (i_Even_Level),
`endif
    .o_Harmonic       (o_Harmonic),
    .o_Next_Sample    (o_Next_Sample),
    .o_Sample         (o_Sample),
    .o_Sample_Valid   (o_Sample_Valid),
    .o_Busy           (o_Busy),
    .o_Overrun        (o_Overrun)
  );

  typedef struct {
    int sample;
    int pulses;
  } exp_t;

  int   n_checks = 0;
  int   n_fail = 0;
  int   tbl [256];
  int   fth = -1;
  int   dp_dly = 0;
  int   pulse_cnt = 0;
  int   valid_cnt = 0;
  int   v0;
  int   t;
  exp_t sb[$];
  exp_t mon_e;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int n);
    exp_t e;
    int   acc = 0;
    int   nn = (n == 0) ? 1 : n;
    e.pulses = nn;
    for (int k = 0; k < nn; k++) begin
      if (k == fth) begin
        e.pulses = k + 1;
        break;
      end
`ifdef HARMONIC_LEVEL_EN
      if (k == 0) acc += tbl[k];
      else acc += (tbl[k] * int'((k % 2 == 0) ? i_Odd_Level : i_Even_Level)) >>> 8;
`else
      acc += tbl[k];
`endif
    end
    acc = acc >>> 4;
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    e.sample = acc;
    return e;
  endfunction

  // Datapath: drops ready on each consumed sample, reloads after 1..3 cycles.
  initial forever begin
    @(negedge clk);
    if (i_Reset) begin
      i_Sample_Ready = 1'b1;
      dp_dly = 0;
    end else begin
      if (dp_dly > 0) begin
        dp_dly--;
        if (dp_dly == 0) i_Sample_Ready = 1'b1;
      end
      if (o_Next_Sample) begin
        i_Sample_Ready = 1'b0;
        dp_dly = 1 + int'($urandom_range(0, 2));
      end
    end
    i_Sample_Value  = 16'(tbl[o_Harmonic]);
    i_Freq_Too_High = (int'(o_Harmonic) == fth);
  end

  initial forever begin
    @(negedge clk);
    if (i_Reset) begin
      pulse_cnt = 0;
    end else if (o_Sample_Valid) begin
      valid_cnt++;
      pulse_cnt++;
      check("finish_next", int'(o_Next_Sample), 1);
      check("finish_harmonic", int'(o_Harmonic), 0);
      if (sb.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("sample", int'($signed(o_Sample)), mon_e.sample);
        check("next_pulses", pulse_cnt, mon_e.pulses);
      end
      pulse_cnt = 0;
    end else if (o_Next_Sample) begin
      pulse_cnt++;
      check("advance_harmonic", int'(o_Harmonic), pulse_cnt);
    end
  end

  task automatic start_frame(input int n);
    sb.push_back(model(n));
    @(negedge clk);
    i_Harmonic_Count = 8'(n);
    i_Sample_Tick = 1'b1;
    @(negedge clk);
    i_Sample_Tick = 1'b0;
  endtask

  task automatic wait_idle();
    t = 0;
    while ((sb.size() != 0 || o_Busy) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) check("frame_timeout", t, 0);
  endtask

  task automatic run(input int n);
    start_frame(n);
    wait_idle();
  endtask

  initial begin
    for (int k = 0; k < 256; k++) tbl[k] = 0;
    repeat (3) @(negedge clk);
    check("rst_harmonic", int'(o_Harmonic), 0);
    check("rst_next", int'(o_Next_Sample), 0);
    check("rst_sample", int'(o_Sample), 0);
    check("rst_valid", int'(o_Sample_Valid), 0);
    check("rst_busy", int'(o_Busy), 0);
    check("rst_overrun", int'(o_Overrun), 0);
    i_Reset = 1'b0;
    @(negedge clk);

    tbl[0] = 1000; tbl[1] = 2000; tbl[2] = 3000; tbl[3] = 4000;
    fth = -1;
    run(4);
    check("n4_sample_625", int'($signed(o_Sample)), 625);

    // Abort a frame at harmonic 3 with reset.
    for (int k = 0; k < 8; k++) tbl[k] = 500;
    v0 = valid_cnt;
    start_frame(8);
    t = 0;
    while (o_Harmonic != 8'd3 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("reach_harmonic3", int'(o_Harmonic), 3);
    i_Reset = 1'b1;
    @(negedge clk);
    check("abort_harmonic", int'(o_Harmonic), 0);
    check("abort_sample", int'(o_Sample), 0);
    check("abort_busy", int'(o_Busy), 0);
    check("abort_next", int'(o_Next_Sample), 0);
    i_Reset = 1'b0;
    sb.delete();
    repeat (4) @(negedge clk);
    check("abort_no_valid", valid_cnt, v0);

    for (int k = 0; k < 8; k++) tbl[k] = 100 * (k + 1);
    fth = 5;
    run(8);
    fth = -1;

    for (int k = 0; k < 256; k++) tbl[k] = 32767;
    run(255);
    check("sat_pos", int'($signed(o_Sample)), 32767);
    for (int k = 0; k < 256; k++) tbl[k] = -32768;
    run(255);
    check("sat_neg", int'($signed(o_Sample)), -32768);

    // Overrun: a tick mid-frame is flagged and dropped.
    for (int k = 0; k < 4; k++) tbl[k] = 300 * (k + 1);
    v0 = valid_cnt;
    start_frame(4);
    repeat (3) @(negedge clk);
    check("ovr_busy", int'(o_Busy), 1);
    i_Sample_Tick = 1'b1;
    @(negedge clk);
    i_Sample_Tick = 1'b0;
    check("ovr_pulse", int'(o_Overrun), 1);
    @(negedge clk);
    check("ovr_clear", int'(o_Overrun), 0);
    wait_idle();
    repeat (6) @(negedge clk);
    check("ovr_no_restart", int'(o_Busy), 0);
    check("ovr_one_valid", valid_cnt - v0, 1);

    tbl[0] = 1600;
    run(0);
    check("count0_pos", int'($signed(o_Sample)), 100);
    tbl[0] = -1000;
    run(0);
    check("count0_neg", int'($signed(o_Sample)), -63);

    fth = 0;
    tbl[0] = 20000;
    run(6);
    check("fth0_zero", int'($signed(o_Sample)), 0);

    for (int r = 0; r < 6; r++) begin
      int n;
      n = int'($urandom_range(1, 20));
      for (int k = 0; k < 256; k++) tbl[k] = int'($urandom_range(0, 65535)) - 32768;
      fth = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      run(n);
    end
    fth = -1;

`ifdef HARMONIC_LEVEL_EN
    i_Odd_Level = 8'd128;
    i_Even_Level = 8'd0;
    for (int k = 0; k < 3; k++) tbl[k] = 4096;
    run(3);
    check("level_384", int'($signed(o_Sample)), 384);
`endif

    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, got busy=%0d expected completion", o_Busy);
    $fatal(1, "watchdog");
  end
endmodule
